// File: rtl/rtc_bus_driver.sv
// ---------------------------------------------------------------------------
// rtc_bus_driver
//
// Bus transaction engine for the RTC multiplexed address/data port. Accepts a
// write or read request from the RTC control FSM and runs one address phase
// (strobe low, then high for hold) followed by one data phase on the pins.
// Each of the four half-phases lasts PHASE_CYCLES clocks, followed by a single
// DONE cycle that pulses donew or doner. The AD bus tristate buffer lives at the
// top level and is built from ad_o / ad_oe / ad_i.
//
// Parameters
//   PHASE_CYCLES : clocks per half-phase (1..255)
//   CNT_W        : phase counter width, must hold PHASE_CYCLES-1
//
// Ports
//   clock, reset     : system clock, synchronous active-high reset
//   win, rin         : write / read request levels, sampled only in IDLE
//   address, datawr  : register address and write data, latched at start
//   donew, doner     : one-cycle completion pulses (write / read)
//   dataread         : last captured read byte, held until the next capture
//   busy             : high whenever the engine is not IDLE
//   cs_n, rd_n, wr_n : active-low chip select and strobes
//   a_d              : 0 = address phase, 1 = data phase
//   ad_o, ad_oe      : bus output value and output enable
//   ad_i             : bus input value, captured on reads
//
// Every output is a flop. Output values are decoded from the next-state
// signals so that the pins change on the same edge as the state register.
// ---------------------------------------------------------------------------
module rtc_bus_driver #(
  parameter int PHASE_CYCLES = 10,
  parameter int CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       win,
  input  logic       rin,
  input  logic [7:0] address,
  input  logic [7:0] datawr,
  output logic       donew,
  output logic       doner,
  output logic [7:0] dataread,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic [7:0] ad_o,
  output logic       ad_oe,
  input  logic [7:0] ad_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADR_LO = 3'd1,
    ADR_HI = 3'd2,
    DAT_LO = 3'd3,
    DAT_HI = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  // Control state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       dataread_q, dataread_d;

  // Registered pin / handshake outputs
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a_d_q, a_d_d;
  logic [7:0] ad_o_q, ad_o_d;
  logic       ad_oe_q, ad_oe_d;
  logic       donew_q, donew_d;
  logic       doner_q, doner_d;
  logic       busy_q, busy_d;

  logic phase_end_s;

  assign phase_end_s = (cnt_q == PHASE_LAST);

  // Next-state, phase counter, request latch and read capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    dataread_d = dataread_q;

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        // Write has priority when both requests are present.
        if (win) begin
          op_d    = OP_WRITE;
          addr_d  = address;
          data_d  = datawr;
          state_d = ADR_LO;
        end else if (rin) begin
          op_d    = OP_READ;
          addr_d  = address;
          data_d  = datawr;
          state_d = ADR_LO;
        end else begin
          state_d = IDLE;
        end
      end

      ADR_LO: begin
        if (phase_end_s) begin
          state_d = ADR_HI;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ADR_HI: begin
        if (phase_end_s) begin
          state_d = DAT_LO;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DAT_LO: begin
        if (phase_end_s) begin
          state_d = DAT_HI;
          cnt_d   = CNT_ZERO;
          // Sample the bus at the very end of the RD# low window, when the
          // RTC has had the full phase to drive valid data.
          if (op_q == OP_READ) begin
            dataread_d = ad_i;
          end else begin
            dataread_d = dataread_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DAT_HI: begin
        if (phase_end_s) begin
          state_d = DONE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        // Always return through IDLE so the requester can advance its
        // address on the done edge before the next request is latched.
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Pin and handshake decode for the state being entered
  always_comb begin
    cs_n_d  = 1'b1;
    rd_n_d  = 1'b1;
    wr_n_d  = 1'b1;
    a_d_d   = 1'b1;
    ad_o_d  = 8'h00;
    ad_oe_d = 1'b0;
    donew_d = 1'b0;
    doner_d = 1'b0;
    busy_d  = (state_d != IDLE);

    case (state_d)
      IDLE: begin
        busy_d = 1'b0;
      end

      ADR_LO: begin
        // The address is always written into the RTC, for reads as well.
        cs_n_d  = 1'b0;
        wr_n_d  = 1'b0;
        a_d_d   = 1'b0;
        ad_oe_d = 1'b1;
        ad_o_d  = addr_d;
      end

      ADR_HI: begin
        // Keep driving the address after the strobe rises (hold time).
        a_d_d   = 1'b0;
        ad_oe_d = 1'b1;
        ad_o_d  = addr_d;
      end

      DAT_LO: begin
        cs_n_d = 1'b0;
        if (op_d == OP_WRITE) begin
          wr_n_d  = 1'b0;
          ad_oe_d = 1'b1;
          ad_o_d  = data_d;
        end else begin
          // Release the bus on the first read data cycle to avoid contention.
          rd_n_d  = 1'b0;
          ad_oe_d = 1'b0;
          ad_o_d  = 8'h00;
        end
      end

      DAT_HI: begin
        if (op_d == OP_WRITE) begin
          ad_oe_d = 1'b1;
          ad_o_d  = data_d;
        end else begin
          ad_oe_d = 1'b0;
          ad_o_d  = 8'h00;
        end
      end

      DONE: begin
        if (op_d == OP_WRITE) begin
          donew_d = 1'b1;
        end else begin
          doner_d = 1'b1;
        end
      end

      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, latched request and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_ZERO;
      op_q       <= OP_WRITE;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      dataread_q <= 8'h00;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      a_d_q      <= 1'b1;
      ad_o_q     <= 8'h00;
      ad_oe_q    <= 1'b0;
      donew_q    <= 1'b0;
      doner_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dataread_q <= dataread_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      a_d_q      <= a_d_d;
      ad_o_q     <= ad_o_d;
      ad_oe_q    <= ad_oe_d;
      donew_q    <= donew_d;
      doner_q    <= doner_d;
      busy_q     <= busy_d;
    end
  end

  assign cs_n     = cs_n_q;
  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign a_d      = a_d_q;
  assign ad_o     = ad_o_q;
  assign ad_oe    = ad_oe_q;
  assign donew    = donew_q;
  assign doner    = doner_q;
  assign busy     = busy_q;
  assign dataread = dataread_q;

endmodule

// File: tb/tb_rtc_bus_driver.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_driver
//
// Directed bench for rtc_bus_driver. Two instances run side by side: one with
// PHASE_CYCLES=2 for the main transaction scenarios and one with
// PHASE_CYCLES=1 for the single-cycle-phase read. Expected pin values per
// cycle are written out as constants; cycle 0 is the cycle in which the
// request is presented to an IDLE engine.
//
// Observed vector layout (24 bits):
//   {cs_n, rd_n, wr_n, a_d, ad_oe, busy, donew, doner, ad_o[7:0], dataread[7:0]}
// ---------------------------------------------------------------------------
module tb_rtc_bus_driver;

  // Pin patterns {cs_n, rd_n, wr_n, a_d, ad_oe, busy, donew, doner}
  localparam logic [7:0] P_IDLE   = 8'b1111_0000;
  localparam logic [7:0] P_ADR_LO = 8'b0100_1100;
  localparam logic [7:0] P_ADR_HI = 8'b1110_1100;
  localparam logic [7:0] P_DLO_WR = 8'b0101_1100;
  localparam logic [7:0] P_DHI_WR = 8'b1111_1100;
  localparam logic [7:0] P_DNE_WR = 8'b1111_0110;
  localparam logic [7:0] P_DLO_RD = 8'b0011_0100;
  localparam logic [7:0] P_DHI_RD = 8'b1111_0100;
  localparam logic [7:0] P_DNE_RD = 8'b1111_0101;

  logic clock;
  logic reset;

  // PHASE_CYCLES = 2 instance
  logic       win_2, rin_2;
  logic [7:0] address_2, datawr_2, ad_i_2;
  logic       donew_2, doner_2, busy_2, cs_n_2, rd_n_2, wr_n_2, a_d_2, ad_oe_2;
  logic [7:0] dataread_2, ad_o_2;

  // PHASE_CYCLES = 1 instance
  logic       win_1, rin_1;
  logic [7:0] address_1, datawr_1, ad_i_1;
  logic       donew_1, doner_1, busy_1, cs_n_1, rd_n_1, wr_n_1, a_d_1, ad_oe_1;
  logic [7:0] dataread_1, ad_o_1;

  logic [23:0] obs_2, obs_1;

  int n_cmp;
  int n_err;

  logic [23:0] exp_tab [1:10];
  logic [7:0]  adi_tab [1:10];
  logic [23:0] exp_p1  [1:6];

  rtc_bus_driver #(.PHASE_CYCLES(2), .CNT_W(8)) u_dut_p2 (
    .clock    (clock),
    .reset    (reset),
    .win      (win_2),
    .rin      (rin_2),
    .address  (address_2),
    .datawr   (datawr_2),
    .donew    (donew_2),
    .doner    (doner_2),
    .dataread (dataread_2),
    .busy     (busy_2),
    .cs_n     (cs_n_2),
    .rd_n     (rd_n_2),
    .wr_n     (wr_n_2),
    .a_d      (a_d_2),
    .ad_o     (ad_o_2),
    .ad_oe    (ad_oe_2),
    .ad_i     (ad_i_2)
  );

  rtc_bus_driver #(.PHASE_CYCLES(1), .CNT_W(8)) u_dut_p1 (
    .clock    (clock),
    .reset    (reset),
    .win      (win_1),
    .rin      (rin_1),
    .address  (address_1),
    .datawr   (datawr_1),
    .donew    (donew_1),
    .doner    (doner_1),
    .dataread (dataread_1),
    .busy     (busy_1),
    .cs_n     (cs_n_1),
    .rd_n     (rd_n_1),
    .wr_n     (wr_n_1),
    .a_d      (a_d_1),
    .ad_o     (ad_o_1),
    .ad_oe    (ad_oe_1),
    .ad_i     (ad_i_1)
  );

  assign obs_2 = {cs_n_2, rd_n_2, wr_n_2, a_d_2, ad_oe_2, busy_2, donew_2, doner_2,
                  ad_o_2, dataread_2};
  assign obs_1 = {cs_n_1, rd_n_1, wr_n_1, a_d_1, ad_oe_1, busy_1, donew_1, doner_1,
                  ad_o_1, dataread_1};

  // 100 MHz clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected P=2 transaction, cycles 1..10. drb/dra = dataread before/after capture.
  task automatic fill_tab(input bit rd, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] drb, input logic [7:0] dra, input logic [7:0] adi);
    exp_tab[1]  = {P_ADR_LO, a, drb};
    exp_tab[2]  = {P_ADR_LO, a, drb};
    exp_tab[3]  = {P_ADR_HI, a, drb};
    exp_tab[4]  = {P_ADR_HI, a, drb};
    exp_tab[5]  = rd ? {P_DLO_RD, 8'h00, drb} : {P_DLO_WR, d, drb};
    exp_tab[6]  = rd ? {P_DLO_RD, 8'h00, drb} : {P_DLO_WR, d, drb};
    exp_tab[7]  = rd ? {P_DHI_RD, 8'h00, dra} : {P_DHI_WR, d, drb};
    exp_tab[8]  = rd ? {P_DHI_RD, 8'h00, dra} : {P_DHI_WR, d, drb};
    exp_tab[9]  = rd ? {P_DNE_RD, 8'h00, dra} : {P_DNE_WR, 8'h00, drb};
    exp_tab[10] = {P_IDLE, 8'h00, (rd ? dra : drb)};
    // Valid read data only while RD# is low; garbage elsewhere
    for (int i = 1; i <= 10; i++) begin
      adi_tab[i] = (i == 5 || i == 6) ? adi : ~adi;
    end
  endtask

  // Walk cycles 1..10 of a P=2 transaction already requested in cycle 0
  task automatic run_table(input string tag, input bit hold_req);
    for (int c = 1; c <= 10; c++) begin
      tick();
      ad_i_2 = adi_tab[c];
      if (!hold_req && c == 1) begin
        win_2 = 1'b0;
        rin_2 = 1'b0;
      end
      check_eq($sformatf("%s_c%0d", tag, c), {8'h00, obs_2}, {8'h00, exp_tab[c]});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    win_2 = 1'b0; rin_2 = 1'b0; address_2 = 8'h00; datawr_2 = 8'h00; ad_i_2 = 8'h00;
    win_1 = 1'b0; rin_1 = 1'b0; address_1 = 8'h00; datawr_1 = 8'h00; ad_i_1 = 8'h00;

    // Reset state
    tick();
    tick();
    check_eq("reset_p2", {8'h00, obs_2}, {8'h00, P_IDLE, 8'h00, 8'h00});
    check_eq("reset_p1", {8'h00, obs_1}, {8'h00, P_IDLE, 8'h00, 8'h00});
    reset = 1'b0;
    tick();
    check_eq("idle_p2", {8'h00, obs_2}, {8'h00, P_IDLE, 8'h00, 8'h00});

    // Write 0x45 to 0x21
    win_2 = 1'b1; address_2 = 8'h21; datawr_2 = 8'h45;
    fill_tab(1'b0, 8'h21, 8'h45, 8'h00, 8'h00, 8'h00);
    run_table("wr21", 1'b0);

    // Read from 0x26, RTC returns 0x37 while RD# is low
    rin_2 = 1'b1; address_2 = 8'h26; datawr_2 = 8'hEE;
    fill_tab(1'b1, 8'h26, 8'h00, 8'h00, 8'h37, 8'h37);
    run_table("rd26", 1'b0);

    // Back-to-back writes with win held; requester advances the address
    // once the first done pulse has been seen.
    win_2 = 1'b1; address_2 = 8'h02; datawr_2 = 8'h11;
    fill_tab(1'b0, 8'h02, 8'h11, 8'h37, 8'h37, 8'h00);
    run_table("b2b_first", 1'b1);
    address_2 = 8'h20; datawr_2 = 8'h22;
    fill_tab(1'b0, 8'h20, 8'h22, 8'h37, 8'h37, 8'h00);
    run_table("b2b_second", 1'b0);

    // Simultaneous requests: write must win, RD# stays high
    win_2 = 1'b1; rin_2 = 1'b1; address_2 = 8'h33; datawr_2 = 8'h7E;
    fill_tab(1'b0, 8'h33, 8'h7E, 8'h37, 8'h37, 8'hC0);
    run_table("both_req", 1'b0);

    // Reset during DAT_LO of a write: abandoned, no donew
    win_2 = 1'b1; address_2 = 8'h44; datawr_2 = 8'h99;
    for (int c = 1; c <= 5; c++) begin
      tick();
      win_2 = 1'b0;
    end
    check_eq("rst_mid_in_dat_lo", {8'h00, obs_2}, {8'h00, P_DLO_WR, 8'h99, 8'h37});
    reset = 1'b1;
    tick();
    check_eq("rst_mid_after", {8'h00, obs_2}, {8'h00, P_IDLE, 8'h00, 8'h00});
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq($sformatf("rst_mid_quiet_c%0d", c), {8'h00, obs_2}, {8'h00, P_IDLE, 8'h00, 8'h00});
    end

    // Read after the abandoned write completes normally
    rin_2 = 1'b1; address_2 = 8'h0F;
    fill_tab(1'b1, 8'h0F, 8'h00, 8'h00, 8'h5A, 8'h5A);
    run_table("rd_after_rst", 1'b0);

    // PHASE_CYCLES=1 read: DAT_LO is cycle 3, doner at cycle 5
    exp_p1[1] = {P_ADR_LO, 8'h3C, 8'h00};
    exp_p1[2] = {P_ADR_HI, 8'h3C, 8'h00};
    exp_p1[3] = {P_DLO_RD, 8'h00, 8'h00};
    exp_p1[4] = {P_DHI_RD, 8'h00, 8'hC3};
    exp_p1[5] = {P_DNE_RD, 8'h00, 8'hC3};
    exp_p1[6] = {P_IDLE,   8'h00, 8'hC3};
    rin_1 = 1'b1; address_1 = 8'h3C; ad_i_1 = 8'h00;
    for (int c = 1; c <= 6; c++) begin
      tick();
      rin_1  = 1'b0;
      ad_i_1 = (c == 3) ? 8'hC3 : 8'h00;
      check_eq($sformatf("p1_rd_c%0d", c), {8'h00, obs_1}, {8'h00, exp_p1[c]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
